// File: rtl/icache_line_fetch_if.sv
// Cache-side line request bus of the instruction-cache refill engine.
//   mem_addr       : byte address of the requested line (bits [3:0] ignored)
//   mem_read_en    : line request, held by the cache until mem_read_valid
//   mem_read_valid : one-cycle pulse, mem_read_data holds the requested line
//   mem_read_data  : 4 x 32-bit line, lane k = word k (byte offset 4k)
// master = cache side, slave = refill engine side.
interface icache_line_fetch_if;
  logic [31:0]       mem_addr;
  logic              mem_read_en;
  logic              mem_read_valid;
  logic [3:0][31:0]  mem_read_data;

  modport master (
    output mem_addr,
    output mem_read_en,
    input  mem_read_valid,
    input  mem_read_data
  );

  modport slave (
    input  mem_addr,
    input  mem_read_en,
    output mem_read_valid,
    output mem_read_data
  );
endinterface

// File: rtl/icache_line_fetch.sv
// Line-refill engine between the instruction cache and a 32-bit synchronous
// word memory. A line request issues four pipelined word reads, the returned
// words are assembled into a 128-bit line and handed back with a one-cycle
// valid pulse. A one-entry buffer answers a repeat of the last filled line
// without touching memory.
// Ports:
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset
//   flush_i    : invalidates the last-line buffer
//   bus        : cache-side request/response bus (slave modport)
//   busy_o     : high while not idle
//   imem_re_o  : word-memory read enable
//   imem_add_o : word address to memory
//   imem_d_i   : word-memory read data, MEM_LAT cycles after imem_re_o
module icache_line_fetch #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned BUF_EN  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  icache_line_fetch_if.slave bus,
  output logic              busy_o,
  output logic              imem_re_o,
  output logic [ADDR_W-1:0] imem_add_o,
  input  logic [31:0]       imem_d_i
);

  localparam int unsigned TagW = ADDR_W - 2;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  logic [TagW-1:0]       tag_q, tag_d;
  logic [1:0]            issue_cnt_q, issue_cnt_d;
  logic [1:0]            rcv_cnt_q, rcv_cnt_d;
  logic [MEM_LAT-1:0]    ret_pipe_q, ret_pipe_d;
  logic [3:0][31:0]      line_q, line_d;
  logic [3:0][31:0]      data_q, data_d;
  logic [3:0][31:0]      buf_line_q, buf_line_d;
  logic [TagW-1:0]       buf_tag_q, buf_tag_d;
  logic                  buf_valid_q, buf_valid_d;
  logic                  flush_seen_q, flush_seen_d;

  logic [TagW-1:0]       req_tag;
  logic                  buf_hit;
  logic                  issue;
  logic                  ret;
  logic [3:0][31:0]      line_next;
  logic                  unused_addr;

  // Upper address bits alias onto the same line; byte offset is irrelevant.
  assign req_tag     = bus.mem_addr[ADDR_W+1:4];
  assign unused_addr = ^{bus.mem_addr[31:ADDR_W+2], bus.mem_addr[3:0]};

  assign buf_hit = (BUF_EN != 0) && buf_valid_q && (buf_tag_q == req_tag) && !flush_i;
  assign issue   = (state_q == StIssue);

  // One bit per read in flight; the oldest bit marks a word returning now.
  assign ret = ret_pipe_q[MEM_LAT-1];

  always_comb begin
    ret_pipe_d[0] = issue;
    for (int unsigned i = 1; i < MEM_LAT; i++) begin
      ret_pipe_d[i] = ret_pipe_q[i-1];
    end
  end

  always_comb begin
    line_next = line_q;
    if (ret) begin
      line_next[rcv_cnt_q] = imem_d_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    issue_cnt_d  = issue_cnt_q;
    rcv_cnt_d    = rcv_cnt_q;
    line_d       = line_q;
    data_d       = data_q;
    buf_line_d   = buf_line_q;
    buf_tag_d    = buf_tag_q;
    buf_valid_d  = buf_valid_q;
    flush_seen_d = flush_seen_q;

    // Returns run independently of the issue side so the two overlap.
    if (ret) begin
      line_d    = line_next;
      rcv_cnt_d = rcv_cnt_q + 2'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.mem_read_en) begin
          if (buf_hit) begin
            state_d = StDone;
            data_d  = buf_line_q;
          end else begin
            state_d      = StIssue;
            tag_d        = req_tag;
            issue_cnt_d  = 2'd0;
            rcv_cnt_d    = 2'd0;
            flush_seen_d = flush_i;
          end
        end
      end
      StIssue: begin
        issue_cnt_d = issue_cnt_q + 2'd1;
        if (issue_cnt_q == 2'd3) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (ret && (rcv_cnt_q == 2'd3)) begin
          state_d = StDone;
          data_d  = line_next;
          // A flush at any point of the fill leaves the buffer invalid.
          if ((BUF_EN != 0) && !flush_seen_q && !flush_i) begin
            buf_line_d  = line_next;
            buf_tag_d   = tag_q;
            buf_valid_d = 1'b1;
          end
        end
      end
      StDone: begin
        // A request still held here is re-sampled next cycle in idle.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (flush_i) begin
      buf_valid_d = 1'b0;
      if (state_q != StIdle) begin
        flush_seen_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      tag_q        <= '0;
      issue_cnt_q  <= '0;
      rcv_cnt_q    <= '0;
      ret_pipe_q   <= '0;
      line_q       <= '0;
      data_q       <= '0;
      buf_line_q   <= '0;
      buf_tag_q    <= '0;
      buf_valid_q  <= 1'b0;
      flush_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      issue_cnt_q  <= issue_cnt_d;
      rcv_cnt_q    <= rcv_cnt_d;
      ret_pipe_q   <= ret_pipe_d;
      line_q       <= line_d;
      data_q       <= data_d;
      buf_line_q   <= buf_line_d;
      buf_tag_q    <= buf_tag_d;
      buf_valid_q  <= buf_valid_d;
      flush_seen_q <= flush_seen_d;
    end
  end

  assign busy_o             = (state_q != StIdle);
  assign imem_re_o          = issue;
  assign imem_add_o         = issue ? {tag_q, issue_cnt_q} : '0;
  assign bus.mem_read_valid = (state_q == StDone);
  assign bus.mem_read_data  = data_q;

endmodule

// File: tb/tb_icache_line_fetch.sv
// Bench for icache_line_fetch: three instances (MEM_LAT 1, 2, 4) with word
// memories whose word a holds 0xA000_0000 + a; non-read cycles return noise.
module tb_icache_line_fetch;
  localparam int unsigned AW = 12;

  typedef struct {
    int           lat;
    int           pulses;
    logic [127:0] line;
    int           reads;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  icache_line_fetch_if bus1 ();
  icache_line_fetch_if bus2 ();
  icache_line_fetch_if bus4 ();

  logic          re1, re2, re4;
  logic [AW-1:0] add1, add2, add4;
  logic [31:0]   d1, d2, d4;
  logic          busy1, busy2, busy4;

  icache_line_fetch #(.ADDR_W(AW), .MEM_LAT(1), .BUF_EN(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(bus1), .busy_o(busy1),
    .imem_re_o(re1), .imem_add_o(add1), .imem_d_i(d1)
  );
  icache_line_fetch #(.ADDR_W(AW), .MEM_LAT(2), .BUF_EN(1)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(bus2), .busy_o(busy2),
    .imem_re_o(re2), .imem_add_o(add2), .imem_d_i(d2)
  );
  icache_line_fetch #(.ADDR_W(AW), .MEM_LAT(4), .BUF_EN(1)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(bus4), .busy_o(busy4),
    .imem_re_o(re4), .imem_add_o(add4), .imem_d_i(d4)
  );

  function automatic logic [31:0] mword(input logic [AW-1:0] a);
    return 32'hA000_0000 + 32'(a);
  endfunction

  function automatic logic [127:0] exp_line(input logic [31:0] addr);
    logic [127:0]  l;
    logic [AW-1:0] w;
    for (int k = 0; k < 4; k++) begin
      w = {addr[AW+1:4], 2'(k)};
      l[k*32 +: 32] = mword(w);
    end
    return l;
  endfunction

  // Word memories with 1, 2 and 4 cycles of read latency.
  logic [31:0] p1;
  logic [31:0] p2 [2];
  logic [31:0] p4 [4];
  always @(posedge clk) begin
    p1    <= re1 ? mword(add1) : $urandom;
    p2[0] <= re2 ? mword(add2) : $urandom;
    p2[1] <= p2[0];
    p4[0] <= re4 ? mword(add4) : $urandom;
    for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
  end
  assign d1 = p1;
  assign d2 = p2[1];
  assign d4 = p4[3];

  // Read monitor, sampled mid-cycle.
  int            cyc = 0;
  int            rd1 = 0, rd2 = 0, rd4 = 0;
  logic [AW-1:0] aq[$];
  int            cq[$];
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (re1 === 1'b1) begin
      rd1 = rd1 + 1;
      aq.push_back(add1);
      cq.push_back(cyc);
    end
    if (re2 === 1'b1) rd2 = rd2 + 1;
    if (re4 === 1'b1) rd4 = rd4 + 1;
  end

  int total = 0;
  int bad   = 0;

  // Reference model of the last-line buffer.
  bit            mb_valid = 1'b0;
  logic [AW-3:0] mb_tag   = '0;

  // Drives one request on dut1 (flush_at: -1 none, 0 with the request, k in
  // cycle T+k), observes for 16 cycles and updates the model.
  task automatic run_req(input logic [31:0] addr, input int flush_at,
                         output obs_t o, output obs_t e);
    logic [AW-3:0] tag;
    bit            hit;
    int            rd0;
    tag      = addr[AW+1:4];
    hit      = mb_valid && (mb_tag == tag) && (flush_at != 0);
    e.lat    = hit ? 1 : 6;
    e.pulses = 1;
    e.line   = exp_line(addr);
    e.reads  = hit ? 0 : 4;
    o.lat    = 0;
    o.pulses = 0;
    o.line   = '0;
    o.reads  = 0;
    aq.delete();
    cq.delete();
    rd0 = rd1;
    bus1.mem_addr    = addr;
    bus1.mem_read_en = 1'b1;
    flush            = (flush_at == 0);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) bus1.mem_addr = $urandom;
      flush = (flush_at == k);
      if (bus1.mem_read_valid === 1'b1) begin
        o.pulses = o.pulses + 1;
        if (o.pulses == 1) begin
          o.lat  = k;
          o.line = bus1.mem_read_data;
        end
        bus1.mem_read_en = 1'b0;
      end
    end
    bus1.mem_read_en = 1'b0;
    flush            = 1'b0;
    o.reads          = rd1 - rd0;
    if (flush_at >= 0) mb_valid = 1'b0;
    else if (!hit) begin
      mb_valid = 1'b1;
      mb_tag   = tag;
    end
  endtask

  task automatic test_reset();
    obs_t o, e;
    rst              = 1'b1;
    flush            = 1'b0;
    bus1.mem_addr    = 32'h0000_0040;
    bus1.mem_read_en = 1'b1;
    bus2.mem_addr    = '0;
    bus2.mem_read_en = 1'b0;
    bus4.mem_addr    = '0;
    bus4.mem_read_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (re1 !== 1'b0) begin
        bad++;
        $display("FAIL reset_re cyc%0d: got %b want 0", i, re1);
      end
      total++;
      if (bus1.mem_read_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_valid cyc%0d: got %b want 0", i, bus1.mem_read_valid);
      end
    end
    total++;
    if (bus1.mem_read_data !== 128'h0) begin
      bad++;
      $display("FAIL reset_data: got %h want 0", bus1.mem_read_data);
    end
    total++;
    if (busy1 !== 1'b0 || add1 !== '0) begin
      bad++;
      $display("FAIL reset_busy_add: got %b/%h want 0/0", busy1, add1);
    end
    rst              = 1'b0;
    bus1.mem_read_en = 1'b0;
    mb_valid         = 1'b0;
    run_req(32'h0000_0040, -1, o, e);
    total++;
    if (o.lat !== e.lat || o.reads !== e.reads) begin
      bad++;
      $display("FAIL reset_first_req lat/reads: got %0d/%0d want %0d/%0d",
               o.lat, o.reads, e.lat, e.reads);
    end
  endtask

  task automatic test_miss_fill();
    obs_t          o, e;
    logic [AW-1:0] want;
    run_req(32'h0000_0124, -1, o, e);
    total++;
    if (o.lat !== 6 || o.pulses !== 1) begin
      bad++;
      $display("FAIL miss_lat/pulses: got %0d/%0d want 6/1", o.lat, o.pulses);
    end
    total++;
    if (o.line !== e.line) begin
      bad++;
      $display("FAIL miss_line: got %h want %h", o.line, e.line);
    end
    total++;
    if (aq.size() !== 4) begin
      bad++;
      $display("FAIL miss_reads: got %0d want 4", aq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        want = 12'h048 + 12'(i);
        total++;
        if (aq[i] !== want || cq[i] !== cq[0] + i) begin
          bad++;
          $display("FAIL miss_addr%0d: got %h@%0d want %h@%0d", i, aq[i], cq[i], want,
                   cq[0] + i);
        end
      end
    end
    total++;
    if (bus1.mem_read_data !== e.line) begin
      bad++;
      $display("FAIL miss_hold: got %h want %h", bus1.mem_read_data, e.line);
    end
  endtask

  task automatic test_buffer_hit();
    obs_t o, e;
    run_req(32'h0000_0128, -1, o, e);
    total++;
    if (o.lat !== 1 || o.reads !== 0 || o.pulses !== 1) begin
      bad++;
      $display("FAIL hit_lat/reads/pulses: got %0d/%0d/%0d want 1/0/1",
               o.lat, o.reads, o.pulses);
    end
    total++;
    if (o.line !== e.line) begin
      bad++;
      $display("FAIL hit_line: got %h want %h", o.line, e.line);
    end
    run_req(32'h0000_0130, -1, o, e);
    total++;
    if (o.lat !== 6 || o.reads !== 4 || aq.size() != 4 || aq[0] !== 12'h04C
        || aq[3] !== 12'h04F) begin
      bad++;
      $display("FAIL next_line_miss lat/reads: got %0d/%0d want 6/4", o.lat, o.reads);
    end
    total++;
    if (o.line !== e.line) begin
      bad++;
      $display("FAIL next_line_data: got %h want %h", o.line, e.line);
    end
  endtask

  task automatic test_flush();
    obs_t o, e;
    int   fl [4] = '{3, -1, -1, 0};
    int   rw [4] = '{4, 4, 0, 4};
    for (int i = 0; i < 4; i++) begin
      run_req(32'h0000_0100, fl[i], o, e);
      total++;
      if (o.reads !== rw[i] || o.reads !== e.reads) begin
        bad++;
        $display("FAIL flush_step%0d reads: got %0d want %0d", i, o.reads, rw[i]);
      end
      total++;
      if (o.lat !== e.lat || o.line !== e.line || o.pulses !== 1) begin
        bad++;
        $display("FAIL flush_step%0d lat/line: got %0d/%h want %0d/%h", i, o.lat, o.line,
                 e.lat, e.line);
      end
    end
  endtask

  task automatic test_random();
    obs_t        o, e;
    logic [31:0] addr;
    int          fa, r;
    for (int i = 0; i < 24; i++) begin
      addr = $urandom;
      addr[AW+1:4] = 10'h200 + 10'($urandom_range(0, 3));
      r  = $urandom_range(0, 9);
      fa = (r == 0) ? 0 : (r == 1) ? $urandom_range(1, 8) : -1;
      run_req(addr, fa, o, e);
      total++;
      if (o.lat !== e.lat || o.pulses !== e.pulses || o.reads !== e.reads) begin
        bad++;
        $display("FAIL rand%0d lat/pulses/reads: got %0d/%0d/%0d want %0d/%0d/%0d", i,
                 o.lat, o.pulses, o.reads, e.lat, e.pulses, e.reads);
      end
      total++;
      if (o.line !== e.line) begin
        bad++;
        $display("FAIL rand%0d line: got %h want %h", i, o.line, e.line);
      end
    end
  endtask

  task automatic test_latency_sweep();
    logic [31:0]  addr;
    logic [127:0] want;
    int           lat [3] = '{0, 0, 0};
    int           pul [3] = '{0, 0, 0};
    logic [127:0] ln  [3];
    int           wl  [3] = '{6, 7, 9};
    int           r20, r40;
    addr = ($urandom & 32'hFFFF_C00F) | 32'h0000_0A50;
    want = exp_line(addr);
    r20  = rd2;
    r40  = rd4;
    bus1.mem_addr = addr;
    bus2.mem_addr = addr;
    bus4.mem_addr = addr;
    bus1.mem_read_en = 1'b1;
    bus2.mem_read_en = 1'b1;
    bus4.mem_read_en = 1'b1;
    flush = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      flush = 1'b0;
      if (bus1.mem_read_valid === 1'b1) begin
        pul[0]++;
        if (pul[0] == 1) begin lat[0] = k; ln[0] = bus1.mem_read_data; end
        bus1.mem_read_en = 1'b0;
      end
      if (bus2.mem_read_valid === 1'b1) begin
        pul[1]++;
        if (pul[1] == 1) begin lat[1] = k; ln[1] = bus2.mem_read_data; end
        bus2.mem_read_en = 1'b0;
      end
      if (bus4.mem_read_valid === 1'b1) begin
        pul[2]++;
        if (pul[2] == 1) begin lat[2] = k; ln[2] = bus4.mem_read_data; end
        bus4.mem_read_en = 1'b0;
      end
    end
    bus1.mem_read_en = 1'b0;
    bus2.mem_read_en = 1'b0;
    bus4.mem_read_en = 1'b0;
    mb_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (lat[i] !== wl[i] || pul[i] !== 1) begin
        bad++;
        $display("FAIL sweep%0d lat/pulses: got %0d/%0d want %0d/1", i, lat[i], pul[i],
                 wl[i]);
      end
      total++;
      if (ln[i] !== want) begin
        bad++;
        $display("FAIL sweep%0d line: got %h want %h", i, ln[i], want);
      end
    end
    total++;
    if (rd2 - r20 !== 4 || rd4 - r40 !== 4) begin
      bad++;
      $display("FAIL sweep_reads: got %0d/%0d want 4/4", rd2 - r20, rd4 - r40);
    end
  endtask

  task automatic test_reset_mid_fill();
    obs_t o, e;
    bus1.mem_addr    = 32'h0000_0200;
    bus1.mem_read_en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 3) rst = 1'b1;
    end
    @(negedge clk);
    total++;
    if (bus1.mem_read_valid !== 1'b0 || re1 !== 1'b0 || busy1 !== 1'b0 || add1 !== '0) begin
      bad++;
      $display("FAIL midrst_ctrl valid/re/busy/add: got %b/%b/%b/%h want 0/0/0/0",
               bus1.mem_read_valid, re1, busy1, add1);
    end
    total++;
    if (bus1.mem_read_data !== 128'h0) begin
      bad++;
      $display("FAIL midrst_data: got %h want 0", bus1.mem_read_data);
    end
    rst              = 1'b0;
    bus1.mem_read_en = 1'b0;
    mb_valid         = 1'b0;
    run_req(32'h0000_0350, -1, o, e);
    total++;
    if (o.lat !== 6 || o.pulses !== 1 || o.reads !== 4) begin
      bad++;
      $display("FAIL midrst_next lat/pulses/reads: got %0d/%0d/%0d want 6/1/4", o.lat,
               o.pulses, o.reads);
    end
    total++;
    if (o.line !== e.line) begin
      bad++;
      $display("FAIL midrst_next_line: got %h want %h", o.line, e.line);
    end
  endtask

  initial begin
    test_reset();
    test_miss_fill();
    test_buffer_hit();
    test_flush();
    test_latency_sweep();
    test_random();
    test_reset_mid_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
